// File: rtl/aes_key_expansion_multi_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : aes_pkg
//  Description : Shared definitions for the multi-length AES key expansion:
//                key-length encodings, Nk/Nr lookup, GF(2^8) xtime, the
//                initial round constant and the expansion state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

   typedef enum logic [1:0] {
      KEY_128  = 2'd0,
      KEY_192  = 2'd1,
      KEY_256  = 2'd2,
      KEY_RSVD = 2'd3
   } key_len_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   localparam logic [7:0] RCON_INIT = 8'h01;

   // Key length in 32-bit words; the reserved code behaves as AES-128.
   function automatic logic [3:0] nk_of(key_len_t l);
      case (l)
         KEY_192: return 4'd6;
         KEY_256: return 4'd8;
         default: return 4'd4;
      endcase
   endfunction

   function automatic logic [3:0] nr_of(key_len_t l);
      return nk_of(l) + 4'd6;
   endfunction

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Reserved code, or a length the instance was not built to hold, falls
   // back to AES-128.
   function automatic key_len_t eff_len(logic [1:0] raw, int max_bits);
      key_len_t l;
      l = key_len_t'(raw);
      if (l == KEY_RSVD) l = KEY_128;
      if (32 * int'(nk_of(l)) > max_bits) l = KEY_128;
      return l;
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_expansion_multi_if.sv
`default_nettype none
// ============================================================================
//  Interface   : aes_key_expansion_multi_if
//  Description : Control / key / round-key read bundle of the key expansion.
//                master = user side, slave = expansion block.
//  Ports       : En, Key_Len, data_in, Addr_Key (+Dec)  user -> block
//                busy, ready, Num_Rounds, Out_Key      block -> user
//  Options     : KEYEXP_DEC_ORDER_EN adds the Dec signal.
//  Revision    : 1.0  initial release
// ============================================================================
interface aes_key_expansion_multi_if #(
   parameter int ADDR_W = 4
);
   logic              En;
   logic [1:0]        Key_Len;
   logic [255:0]      data_in;
   logic [ADDR_W-1:0] Addr_Key;
   logic              busy;
   logic              ready;
   logic [3:0]        Num_Rounds;
   logic [127:0]      Out_Key;
`ifdef KEYEXP_DEC_ORDER_EN
   logic              Dec;

   modport master (output En, Key_Len, data_in, Addr_Key, Dec,
                   input  busy, ready, Num_Rounds, Out_Key);
   modport slave  (input  En, Key_Len, data_in, Addr_Key, Dec,
                   output busy, ready, Num_Rounds, Out_Key);
`else
   modport master (output En, Key_Len, data_in, Addr_Key,
                   input  busy, ready, Num_Rounds, Out_Key);
   modport slave  (input  En, Key_Len, data_in, Addr_Key,
                   output busy, ready, Num_Rounds, Out_Key);
`endif
endinterface
`default_nettype wire

// File: rtl/aes_key_expansion_multi_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox
//  Description : Combinational forward AES S-box (8 bit in, 8 bit out).
//                Shared between key expansion and the cipher datapath.
//  Ports       : in_byte  - byte to substitute
//                out_byte - substituted byte
//  Revision    : 1.0  initial release
// ============================================================================
module aes_sbox (
   input  wire logic [7:0] in_byte,
   output logic      [7:0] out_byte
);
   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   assign out_byte = SBOX[in_byte];
endmodule
`default_nettype wire

// File: rtl/aes_key_expansion_multi.sv
`default_nettype none
// ============================================================================
//  Module      : aes_key_expansion_multi
//  Description : Run-time selectable AES-128/192/256 key expansion. One
//                32-bit word is produced per clock into internal storage;
//                round keys are read combinationally by index.
//  Ports       : Clk, Rst (async, active high)
//                bus.En / Key_Len / data_in   start request + cipher key
//                bus.Addr_Key (+Dec)          round-key read index
//                bus.busy / ready             expansion status
//                bus.Num_Rounds / Out_Key     Nr and selected round key
//  Options     : KEYEXP_DEC_ORDER_EN - Dec=1 reads round key Nr-Addr_Key.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_key_expansion_multi
   import aes_pkg::*;
#(
   parameter int MAX_KEY_BITS = 256,
   parameter int ADDR_W       = 4
) (
   input  wire logic                Clk,
   input  wire logic                Rst,
   aes_key_expansion_multi_if.slave bus
);
   localparam int NR_MAX = MAX_KEY_BITS / 32 + 6;
   localparam int DEPTH  = 4 * (NR_MAX + 1);
   localparam int IDX_W  = 6;   // storage never exceeds 60 words

   state_t           state;
   key_len_t         len;
   logic [31:0]      w [DEPTH];
   logic [IDX_W-1:0] i;
   logic [2:0]       cnt;       // i mod Nk
   logic [7:0]       rcon;
   logic             busy_q;
   logic             ready_q;

   key_len_t         start_len;
   logic [3:0]       nk;
   logic [3:0]       nr;
   logic [7:0][31:0] key_words;  // key_words[7] is w[0]

   assign start_len = eff_len(bus.Key_Len, MAX_KEY_BITS);
   assign nk        = nk_of(len);
   assign nr        = nr_of(len);
   assign key_words = bus.data_in;

   // ---------------------------------------------------------------- next word
   logic [IDX_W-1:0] idx_prev, idx_back, last_idx;
   logic [31:0]      prev, back, sub_in, sub_out, t, new_word;

   assign idx_prev = i - IDX_W'(1);
   assign idx_back = i - IDX_W'(nk);
   assign last_idx = IDX_W'({nr, 2'b00}) + IDX_W'(3);
   assign prev     = w[idx_prev];
   assign back     = w[idx_back];
   assign sub_in   = (cnt == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

   generate
      for (genvar b = 0; b < 4; b++) begin : g_sbox
         aes_sbox u_sbox (
            .in_byte  (sub_in[8*b +: 8]),
            .out_byte (sub_out[8*b +: 8])
         );
      end
   endgenerate

   always_comb begin
      t = prev;
      if (cnt == 3'd0)
         t = sub_out ^ {rcon, 24'h0};
      else if (nk == 4'd8 && cnt == 3'd4)
         t = sub_out;
   end

   assign new_word = back ^ t;

   // ---------------------------------------------------------------- control
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state   <= ST_IDLE;
         len     <= KEY_128;
         i       <= IDX_W'(4);   // keeps the read indices in range while idle
         cnt     <= 3'd0;
         rcon    <= RCON_INIT;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
         for (int k = 0; k < DEPTH; k++) w[IDX_W'(k)] <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (bus.En) begin
                  len <= start_len;
                  for (int k = 0; k < 8; k++)
                     if (k < int'(nk_of(start_len)))
                        w[IDX_W'(k)] <= key_words[3'(7 - k)];
                  i       <= IDX_W'(nk_of(start_len));
                  cnt     <= 3'd0;
                  rcon    <= RCON_INIT;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
                  state   <= ST_EXPAND;
               end
            end
            ST_EXPAND: begin
               w[i] <= new_word;
               i    <= i + IDX_W'(1);
               cnt  <= ({1'b0, cnt} == nk - 4'd1) ? 3'd0 : cnt + 3'd1;
               if (cnt == 3'd0)
                  rcon <= xtime(rcon);
               if (i == last_idx) begin
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
                  state   <= ST_DONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- read port
   logic [ADDR_W-1:0] rd_addr_raw;
   int                rd_addr;
   int                rd_round;
   logic [IDX_W-1:0]  rd_base;
   logic [127:0]      out_key;

   assign rd_addr_raw = bus.Addr_Key;

   always_comb begin
      rd_addr  = int'(rd_addr_raw);
      rd_round = rd_addr;
`ifdef KEYEXP_DEC_ORDER_EN
      if (bus.Dec) rd_round = int'(nr) - rd_addr;
`endif
      rd_base = IDX_W'(4 * rd_round);
      out_key = '0;
      if (rd_addr <= int'(nr))
         out_key = {w[rd_base], w[rd_base + IDX_W'(1)],
                    w[rd_base + IDX_W'(2)], w[rd_base + IDX_W'(3)]};
   end

   assign bus.busy       = busy_q;
   assign bus.ready      = ready_q;
   assign bus.Num_Rounds = nr;
   assign bus.Out_Key    = out_key;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expansion_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_key_expansion_multi
//  Description : Scoreboard bench for aes_key_expansion_multi. Reference
//                round keys come from a FIPS-197 style model whose S-box is
//                derived from GF(2^8) inversion plus the affine map.
//  Options     : KEYEXP_DEC_ORDER_EN enables the decryption-order checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes_key_expansion_multi;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   aes_key_expansion_multi_if #(.ADDR_W(4)) bus ();

   aes_key_expansion_multi #(.MAX_KEY_BITS(256), .ADDR_W(4)) dut (
      .Clk (clk),
      .Rst (rst),
      .bus (bus)
   );

   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string        name;
      logic [127:0] exp;
   } exp_t;

   exp_t        exp_q [$];
   exp_t        mon_e;
   bit          rd_req   = 1'b0;
   bit          dec_mode = 1'b0;
   logic [7:0]  sb [256];
   logic [31:0] mw [60];
   int          mnr;
   int          mnk;

   task automatic check(string name, logic [127:0] act, logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ------------------------------------------------------------ reference model
   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] b;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         b = inv;
         sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                   ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(logic [31:0] v);
      return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
   endfunction

   task automatic model_expand(int len, logic [255:0] key);
      logic [7:0]  rc;
      logic [31:0] tmp;
      int          total;
      mnk   = (len == 1) ? 6 : (len == 2) ? 8 : 4;
      mnr   = mnk + 6;
      total = 4 * (mnr + 1);
      for (int k = 0; k < mnk; k++) mw[k] = key[255 - 32*k -: 32];
      rc = 8'h01;
      for (int n = mnk; n < total; n++) begin
         tmp = mw[n-1];
         if (n % mnk == 0) begin
            tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
            rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (mnk == 8 && n % mnk == 4) begin
            tmp = subw(tmp);
         end
         mw[n] = mw[n-mnk] ^ tmp;
      end
   endtask

   function automatic logic [127:0] model_key(int a);
      int r;
      if (a > mnr) return '0;
      r = dec_mode ? mnr - a : a;
      return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
   endfunction

   // ------------------------------------------------------------ monitor
   always @(negedge clk) begin
      if (rd_req) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: read seen with no expected entry");
         end else begin
            mon_e = exp_q.pop_front();
            check(mon_e.name, bus.Out_Key, mon_e.exp);
         end
      end
   end

   // ------------------------------------------------------------ stimulus
   // All tasks are entered and left 1 time unit after a rising edge.
   task automatic start_run(int len, logic [255:0] key);
      bus.En      = 1'b1;
      bus.Key_Len = 2'(len);
      bus.data_in = key;
      model_expand(len, key);
      @(posedge clk); #1;
      bus.En      = 1'b0;
      bus.Key_Len = 2'($urandom_range(0, 3));
      bus.data_in = {$urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom};
      check("start_busy", 128'(bus.busy), 128'd1);
      check("start_ready", 128'(bus.ready), 128'd0);
   endtask

   task automatic wait_ready(string tag, int exp_lat, int already);
      int n;
      n = already;
      while (bus.ready !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_latency"}, 128'(n), 128'(exp_lat));
      check({tag, "_busy_done"}, 128'(bus.busy), 128'd0);
      check({tag, "_num_rounds"}, 128'(bus.Num_Rounds), 128'(mnr));
   endtask

   task automatic issue_read(int a, string name, logic [127:0] exp);
      bus.Addr_Key = 4'(a);
      exp_q.push_back('{name, exp});
      rd_req = 1'b1;
      @(posedge clk); #1;
      rd_req = 1'b0;
   endtask

   task automatic read_all(string tag);
      for (int a = 0; a < 16; a++)
         issue_read(a, $sformatf("%s_key%0d", tag, a), model_key(a));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int len;
      int lat;
      rst          = 1'b1;
      bus.En       = 1'b0;
      bus.Key_Len  = 2'd0;
      bus.data_in  = '0;
      bus.Addr_Key = 4'd0;
`ifdef KEYEXP_DEC_ORDER_EN
      bus.Dec      = 1'b0;
`endif
      build_sbox();
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 128'(bus.busy), 128'd0);
      check("rst_ready", 128'(bus.ready), 128'd0);
      check("rst_num_rounds", 128'(bus.Num_Rounds), 128'd10);
      check("rst_out_key", bus.Out_Key, 128'd0);
      rst = 1'b0;

      // Known-answer vectors
      start_run(0, K128);
      wait_ready("v128", 40, 0);
      read_all("v128");
      issue_read(0, "v128_const_key0", 128'h2b7e151628aed2a6abf7158809cf4f3c);
      issue_read(10, "v128_const_key10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      start_run(1, K192);
      wait_ready("v192", 46, 0);
      read_all("v192");
      issue_read(12, "v192_const_key12", 128'he98ba06f448c773c8ecc720401002202);

      start_run(2, K256);
      wait_ready("v256", 52, 0);
      read_all("v256");
      issue_read(14, "v256_const_key14", 128'hfe4890d1e6188d0b046df344706c631e);

      // Asynchronous reset in the middle of an expansion
      start_run(2, K256);
      bus.Addr_Key = 4'd0;
      repeat (19) begin @(posedge clk); #1; end
      #2 rst = 1'b1;
      #1;
      check("midrst_busy", 128'(bus.busy), 128'd0);
      check("midrst_ready", 128'(bus.ready), 128'd0);
      check("midrst_num_rounds", 128'(bus.Num_Rounds), 128'd10);
      check("midrst_out_key", bus.Out_Key, 128'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      start_run(2, K256);
      wait_ready("after_rst", 52, 0);
      read_all("after_rst");

      // Restart from DONE: 128 then 256
      start_run(0, K128);
      wait_ready("pre_restart", 40, 0);
      start_run(2, K256);
      wait_ready("restart", 52, 0);
      read_all("restart");
      issue_read(15, "restart_addr15", 128'd0);
      issue_read(14, "restart_const_key14", 128'hfe4890d1e6188d0b046df344706c631e);

      // Randomized runs; En pulses during EXPAND must be ignored
      for (int r = 0; r < 8; r++) begin
         len = $urandom_range(0, 3);
         start_run(len, {$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom});
         lat = 4 * (mnr + 1) - mnk;
         repeat (4) begin @(posedge clk); #1; end
         bus.En      = 1'b1;
         bus.Key_Len = 2'($urandom_range(0, 3));
         @(posedge clk); #1;
         bus.En = 1'b0;
         wait_ready($sformatf("rand%0d", r), lat, 5);
         read_all($sformatf("rand%0d", r));
      end

`ifdef KEYEXP_DEC_ORDER_EN
      dec_mode = 1'b1;
      bus.Dec  = 1'b1;
      start_run(0, K128);
      wait_ready("dec128", 40, 0);
      read_all("dec128");
      issue_read(0, "dec128_const_addr0", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      issue_read(10, "dec128_const_addr10", 128'h2b7e151628aed2a6abf7158809cf4f3c);
      start_run(2, K256);
      wait_ready("dec256", 52, 0);
      read_all("dec256");
      dec_mode = 1'b0;
      bus.Dec  = 1'b0;
`endif

      repeat (2) @(posedge clk);
      #1;
      check("queue_drain", 128'(exp_q.size()), 128'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/aes_key_expansion_multi.md
# aes_key_expansion_multi

Run-time selectable AES key expansion for AES-128, AES-192 and AES-256. It takes a cipher key, generates all round keys at one 32-bit word per cycle, and stores them internally. Round keys are read through a random-access address port. It sits in front of the round datapath and replaces the fixed-length key expansion block, keeping the same `En`/`ready`/`Addr_Key` style of use.

## Interface
- `MAX_KEY_BITS`, 256: largest supported key (128, 192 or 256); sets storage depth to 4·(Nr_max+1) words.
- `ADDR_W`, 4: width of `Addr_Key`.
- `Clk`  in  1  single clock, rising edge.
- `Rst`  in  1  asynchronous, active-high reset.
- `En`  in  1  start request, sampled in IDLE or DONE.
- `Key_Len`  in  2  key length: 0=128, 1=192, 2=256; 3 reserved.
- `data_in`  in  256  cipher key, left-aligned; 128-bit key in [255:128], 192-bit key in [255:64]; unused bits ignored.
- `Addr_Key`  in  ADDR_W  round-key index, 0..Nr.
- `busy`  out  1  expansion in progress.
- `ready`  out  1  all round keys valid.
- `Num_Rounds`  out  4  Nr of the latched length (10/12/14).
- `Out_Key`  out  128  round key `Addr_Key` = {w[4a], w[4a+1], w[4a+2], w[4a+3]}.

## Operation
- Lengths: Nk/Nr = 4/10, 6/12, 8/14. Total words are 44, 52 or 60.
- Reserved `Key_Len`=3 is treated as 128. A length above `MAX_KEY_BITS` is also treated as 128.
- States: IDLE, EXPAND, DONE.
- IDLE or DONE with `En`=1 at an edge:
  - latch `Key_Len`;
  - write w[0..Nk-1] from `data_in`;
  - set i=Nk and Rcon=0x01;
  - set `busy`=1 and `ready`=0;
  - go to EXPAND.
- EXPAND computes one word per edge: w[i] = w[i-Nk] ^ t, where t is:
  - SubWord(RotWord(w[i-1])) ^ {Rcon,24'h0} when i mod Nk = 0; Rcon then advances by xtime (GF(2^8), poly 0x11B);
  - SubWord(w[i-1]) when Nk=8 and i mod 8 = 4;
  - w[i-1] otherwise.
- Track i mod Nk with a counter that wraps at Nk. No divider.
- On the edge writing the final word (i = 4(Nr+1)-1): `busy`=0, `ready`=1, go to DONE.
- DONE holds `ready`=1 until a new `En` or `Rst`. With `En` held high, expansion restarts on every completion.
- `En` during EXPAND is ignored. `Key_Len` and `data_in` are sampled only at the start edge.
- `Out_Key` is combinational from storage.
  - `Addr_Key` > Nr gives 0.
  - Reads during EXPAND return the current storage contents and are not guaranteed valid.

## Timing
- Latency from the `En` sample edge to `ready` high = 4(Nr+1)-Nk edges: 40 (128), 46 (192), 52 (256).
- `Out_Key` is valid in the same cycle `Addr_Key` changes, once `ready`=1.
- Restart from DONE: `ready` falls on the `En` edge. Old keys are overwritten progressively.
- Reset (asynchronous, any state, including mid-EXPAND):
  - state IDLE, `busy`=0, `ready`=0, `Num_Rounds`=10, Rcon=0x01;
  - all storage cleared, so `Out_Key`=0.
- Deassertion of `Rst` is synchronised by the user. The first `En` is accepted on the first edge after release.

## Configuration
- `KEYEXP_DEC_ORDER_EN` defined:
  - adds input `Dec` (1 bit);
  - when `Dec`=1, `Out_Key` returns round key Nr-`Addr_Key`, so the inverse cipher can count up from 0;
  - when `Dec`=0, forward order;
  - out-of-range handling is unchanged.
- Undefined: no `Dec` port; forward order only.

## Structure
- Package `aes_pkg`:
  - `Key_Len` encodings;
  - `nk_of()` and `nr_of()` functions;
  - `xtime()`;
  - Rcon initial value;
  - state encoding.
- Sub-module `aes_sbox`: combinational 8-bit forward S-box, instanced 4× for SubWord. It is shared with the cipher datapath.

## Test plan
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, `En` pulse -> `ready` after 40 edges; `Num_Rounds`=10; key 0 = the key; key 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> `ready` after 46 edges; key 12 = e98ba06f448c773c8ecc720401002202.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> `ready` after 52 edges; key 14 = fe4890d1e6188d0b046df344706c631e.
- `Rst` asserted mid-EXPAND (edge 20), then the 256 vector is started -> immediately `busy`=0, `ready`=0, `Out_Key`=0; the subsequent full run matches the vector.
- Runs 128, then 256 restart from DONE, then `Addr_Key`=15 -> `ready` drops on the restart edge; the final keys are the 256 set; address 15 returns 0.
- With `KEYEXP_DEC_ORDER_EN`, `Dec`=1, AES-128 vector, `Addr_Key`=0 -> d014f9a8c9ee2589e13f0cc8b6630ca6; `Addr_Key`=10 -> the cipher key.
